// File: rtl/nv_nvdla_sdp_dmaif_rd_responder.sv
// SDP DMA read responder: fetches 32 B atoms from a sync RAM and packs two per beat under
// latency-FIFO credit control; first read 1 cycle after accept, beat every 4 cycles, holds payload while rsp_rdy=0.
module nv_nvdla_sdp_dmaif_rd_responder #(
  parameter int AW        = 64,
  parameter int SW        = 15,
  parameter int ADW       = 256,
  parameter int MAW       = 10,
  parameter int CDT_DEPTH = 16,
  localparam int CW       = $clog2(CDT_DEPTH + 1)
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                dma_rd_req_vld,
  output logic                dma_rd_req_rdy,
  input  logic [AW+SW-1:0]    dma_rd_req_pd,
  output logic                dma_rd_rsp_vld,
  input  logic                dma_rd_rsp_rdy,
  output logic [2*ADW+1:0]    dma_rd_rsp_pd,
  input  logic                dma_rd_cdt_lat_fifo_pop,
  output logic                mem_rd_en,
  output logic [MAW-1:0]      mem_rd_addr,
  input  logic [ADW-1:0]      mem_rd_data,
  output logic [CW-1:0]       cdt_cnt,
  output logic                cdt_ovf,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_CAP   = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [MAW-1:0] ptr_q, ptr_d;
  logic [SW:0]    cnt_q, cnt_d;
  logic [1:0]     mask_q, mask_d;
  logic [ADW-1:0] lo_q, lo_d;
  logic [ADW-1:0] hi_q, hi_d;
  logic [CW-1:0]  cdt_q, cdt_d;
  logic           ovf_q, ovf_d;
  logic           live_q;

  logic           req_fire;
  logic           cdt_take;
  logic [SW-1:0]  req_size;
  logic           req_unused;

  assign req_size   = dma_rd_req_pd[AW+SW-1:AW];
  assign req_unused = ^{dma_rd_req_pd[AW-1:MAW+5], dma_rd_req_pd[4:0]};
  assign req_fire   = dma_rd_req_vld && dma_rd_req_rdy;
  // A beat's credit is consumed the moment its first atom read issues.
  assign cdt_take   = (state_q == ST_RD_LO) && (cdt_q != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          ptr_d   = dma_rd_req_pd[MAW+4:5];
          cnt_d   = {1'b0, req_size} + (SW+1)'(1);
          mask_d  = '0;
          lo_d    = '0;
          hi_d    = '0;
          state_d = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        if (cdt_q != '0) begin
          ptr_d = ptr_q + MAW'(1);
          cnt_d = cnt_q - (SW+1)'(1);
          if (cnt_d != '0) begin
            state_d = ST_RD_HI;
          end else begin
            mask_d  = 2'b01;
            state_d = ST_CAP;
          end
        end
      end
      ST_RD_HI: begin
        ptr_d   = ptr_q + MAW'(1);
        cnt_d   = cnt_q - (SW+1)'(1);
        lo_d    = mem_rd_data;
        mask_d  = 2'b11;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        if (mask_q == 2'b11) hi_d = mem_rd_data;
        else                 lo_d = mem_rd_data;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dma_rd_rsp_rdy) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            mask_d  = '0;
            lo_d    = '0;
            hi_d    = '0;
            state_d = ST_RD_LO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop with the counter already full is a client bug: latch it, don't count it.
  always_comb begin
    cdt_d = cdt_q;
    ovf_d = ovf_q;
    if (cdt_take && !dma_rd_cdt_lat_fifo_pop) begin
      cdt_d = cdt_q - CW'(1);
    end else if (!cdt_take && dma_rd_cdt_lat_fifo_pop) begin
      if (cdt_q == CW'(CDT_DEPTH)) ovf_d = 1'b1;
      else                         cdt_d = cdt_q + CW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cdt_q   <= CW'(CDT_DEPTH);
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cdt_q   <= cdt_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  // live_q keeps rdy low while reset is held without looking at the reset pin combinationally.
  assign dma_rd_req_rdy = live_q && (state_q == ST_IDLE);
  assign dma_rd_rsp_vld = (state_q == ST_SEND);
  assign dma_rd_rsp_pd  = {mask_q, hi_q, lo_q};
  assign mem_rd_en      = cdt_take || (state_q == ST_RD_HI);
  assign mem_rd_addr    = ptr_q;
  assign cdt_cnt        = cdt_q;
  assign cdt_ovf        = ovf_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nv_nvdla_sdp_dmaif_rd_responder.sv
// Randomized bench for the SDP DMA read responder against a beat-list reference model.
`timescale 1ns/1ps
module tb_nv_nvdla_sdp_dmaif_rd_responder;
  localparam int AW = 64, SW = 15, ADW = 256, MAW = 10, CDT = 16, CW = 5;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               req_vld = 1'b0;
  logic               req_rdy;
  logic [AW+SW-1:0]   req_pd = '0;
  logic               rsp_vld;
  logic               rsp_rdy = 1'b0;
  logic [2*ADW+1:0]   rsp_pd;
  logic               pop = 1'b0;
  logic               mem_en;
  logic [MAW-1:0]     mem_addr;
  logic [ADW-1:0]     mem_data;
  logic [CW-1:0]      cdt;
  logic               ovf;
  logic               busy;

  logic [ADW-1:0] mem [1024];

  typedef struct packed {
    logic [1:0]     m;
    logic [ADW-1:0] hi;
    logic [ADW-1:0] lo;
  } beat_t;

  beat_t exp_q[$];
  int    outstanding = 0;
  int    total = 0;
  int    bad = 0;

  nv_nvdla_sdp_dmaif_rd_responder dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rstn         (rstn),
    .dma_rd_req_vld          (req_vld),
    .dma_rd_req_rdy          (req_rdy),
    .dma_rd_req_pd           (req_pd),
    .dma_rd_rsp_vld          (rsp_vld),
    .dma_rd_rsp_rdy          (rsp_rdy),
    .dma_rd_rsp_pd           (rsp_pd),
    .dma_rd_cdt_lat_fifo_pop (pop),
    .mem_rd_en               (mem_en),
    .mem_rd_addr             (mem_addr),
    .mem_rd_data             (mem_data),
    .cdt_cnt                 (cdt),
    .cdt_ovf                 (ovf),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: atoms base..base+size (mod 1024), paired low-first into beats.
  task automatic model_req(input logic [AW-1:0] addr, input int size);
    int n;
    int base;
    beat_t b;
    n    = size + 1;
    base = int'(addr[14:5]);
    for (int k = 0; k < n; k += 2) begin
      b.lo = mem[(base + k) % 1024];
      if (k + 1 < n) begin
        b.hi = mem[(base + k + 1) % 1024];
        b.m  = 2'b11;
      end else begin
        b.hi = '0;
        b.m  = 2'b01;
      end
      exp_q.push_back(b);
    end
  endtask

  // Returns one cycle after acceptance (cycle T+1).
  task automatic send_req(input logic [AW-1:0] addr, input int size);
    int w;
    w = 0;
    req_pd  = {SW'(size), addr};
    req_vld = 1'b1;
    while (req_rdy !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    total++;
    if (req_rdy !== 1'b1) begin
      bad++;
      $display("FAIL req_accept: rdy=%b want 1", req_rdy);
    end
    model_req(addr, size);
    step();
    req_vld = 1'b0;
  endtask

  task automatic collect(input int nbeats, input bit rnd_rdy, input bit do_pop);
    int got;
    int cyc;
    bit holding;
    logic [2*ADW+1:0] held;
    got = 0;
    cyc = 0;
    holding = 1'b0;
    held = '0;
    while (got < nbeats && exp_q.size() > 0 && cyc < 2000) begin
      rsp_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      pop = do_pop && (outstanding > 0) && ($urandom_range(0, 1) == 1);
      if (pop) outstanding--;
      if (holding) begin
        total++;
        if (rsp_vld !== 1'b1 || rsp_pd !== held) begin
          bad++;
          $display("FAIL hold_stable: vld=%b pd=%h want vld=1 pd=%h", rsp_vld, rsp_pd, held);
        end
      end
      holding = 1'b0;
      if (rsp_vld === 1'b1) begin
        if (rsp_rdy) begin
          total++;
          if (rsp_pd !== exp_q[0]) begin
            bad++;
            $display("FAIL beat_data: got %h want %h", rsp_pd, exp_q[0]);
          end
          void'(exp_q.pop_front());
          got++;
          outstanding++;
        end else begin
          holding = 1'b1;
          held = rsp_pd;
        end
      end
      step();
      cyc++;
    end
    rsp_rdy = 1'b0;
    pop = 1'b0;
    if (cyc >= 2000) begin
      total++;
      bad++;
      $display("FAIL collect_timeout: got %0d beats want %0d", got, nbeats);
    end
  endtask

  task automatic drain_and_check();
    int w;
    while (outstanding > 0) begin
      pop = 1'b1;
      step();
      outstanding--;
    end
    pop = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 50) begin
      step();
      w++;
    end
    step();
    total++;
    if (cdt !== CW'(CDT) || busy !== 1'b0) begin
      bad++;
      $display("FAIL credits_restored: cdt=%0d busy=%b want cdt=%0d busy=0", cdt, busy, CDT);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if (req_rdy !== 1'b0 || rsp_vld !== 1'b0 || rsp_pd !== '0) begin
      bad++;
      $display("FAIL reset_handshake: rdy=%b vld=%b pd=%h want 0 0 0", req_rdy, rsp_vld, rsp_pd);
    end
    total++;
    if (mem_en !== 1'b0 || mem_addr !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mem: en=%b addr=%0d busy=%b want 0 0 0", mem_en, mem_addr, busy);
    end
    total++;
    if (cdt !== CW'(CDT) || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_cdt: cdt=%0d ovf=%b want %0d 0", cdt, ovf, CDT);
    end
    rstn = 1'b1;
    step();
    total++;
    if (req_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rdy_after_reset: rdy=%b want 1", req_rdy);
    end
  endtask

  task automatic test_single();
    logic [ADW-1:0] a;
    logic [2*ADW+1:0] want;
    a = {8{$urandom()}};
    mem[2] = a;
    send_req(64'h40, 0);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd2) begin
      bad++;
      $display("FAIL single_read: en=%b addr=%0d want 1 2", mem_en, mem_addr);
    end
    step();
    total++;
    if (rsp_vld !== 1'b0 || cdt !== 5'd15) begin
      bad++;
      $display("FAIL single_t2: vld=%b cdt=%0d want 0 15", rsp_vld, cdt);
    end
    step();
    want = {2'b01, {ADW{1'b0}}, a};
    total++;
    if (rsp_vld !== 1'b1 || rsp_pd !== want) begin
      bad++;
      $display("FAIL single_rsp: vld=%b pd=%h want 1 %h", rsp_vld, rsp_pd, want);
    end
    collect(1, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
    drain_and_check();
  endtask

  task automatic test_three();
    send_req(64'h0, 2);
    collect(2, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0 || cdt !== 5'd14) begin
      bad++;
      $display("FAIL three_end: busy=%b cdt=%0d want 0 14", busy, cdt);
    end
    drain_and_check();
  endtask

  task automatic test_credit_stall();
    int viol;
    send_req(64'h0, 39);
    collect(16, 1'b0, 1'b0);
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_vld !== 1'b0 || mem_en !== 1'b0) viol++;
      step();
    end
    total++;
    if (viol != 0 || busy !== 1'b1 || cdt !== '0) begin
      bad++;
      $display("FAIL stall_hold: viol=%0d busy=%b cdt=%0d want 0 1 0", viol, busy, cdt);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    outstanding--;
    total++;
    if (mem_en !== 1'b1) begin
      bad++;
      $display("FAIL stall_resume: en=%b want 1", mem_en);
    end
    collect(100, 1'b1, 1'b1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_leftover: left=%0d want 0", exp_q.size());
    end
    drain_and_check();
  endtask

  task automatic test_backpressure();
    int w;
    int viol;
    logic [2*ADW+1:0] held;
    logic [CW-1:0] hcdt;
    send_req(64'h100, 3);
    w = 0;
    while (rsp_vld !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    held = rsp_pd;
    hcdt = cdt;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_vld !== 1'b1 || rsp_pd !== held || mem_en !== 1'b0 || cdt !== hcdt) viol++;
      step();
    end
    total++;
    if (w >= 20 || viol != 0) begin
      bad++;
      $display("FAIL backpressure: wait=%0d viol=%0d want <20 0", w, viol);
    end
    collect(2, 1'b0, 1'b1);
    drain_and_check();
  endtask

  task automatic test_wrap();
    send_req(64'h7FE0, 1);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd1023) begin
      bad++;
      $display("FAIL wrap_first: en=%b addr=%0d want 1 1023", mem_en, mem_addr);
    end
    step();
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd0) begin
      bad++;
      $display("FAIL wrap_second: en=%b addr=%0d want 1 0", mem_en, mem_addr);
    end
    step();
    total++;
    if (rsp_vld !== 1'b0) begin
      bad++;
      $display("FAIL wrap_t3: vld=%b want 0", rsp_vld);
    end
    step();
    total++;
    if (rsp_vld !== 1'b1) begin
      bad++;
      $display("FAIL wrap_t4: vld=%b want 1", rsp_vld);
    end
    collect(1, 1'b0, 1'b0);
    drain_and_check();
  endtask

  task automatic test_pop_coincident();
    send_req(64'h20, 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    total++;
    if (cdt !== CW'(CDT) || ovf !== 1'b0) begin
      bad++;
      $display("FAIL pop_coincident: cdt=%0d ovf=%b want %0d 0", cdt, ovf, CDT);
    end
    collect(1, 1'b0, 1'b0);
    outstanding--;
    drain_and_check();
  endtask

  task automatic test_ovf();
    pop = 1'b1;
    step();
    pop = 1'b0;
    total++;
    if (cdt !== CW'(CDT) || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: cdt=%0d ovf=%b want %0d 1", cdt, ovf, CDT);
    end
    send_req({$urandom(), $urandom()}, 3);
    collect(10, 1'b1, 1'b1);
    drain_and_check();
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: ovf=%b want 1", ovf);
    end
  endtask

  task automatic test_reset_mid();
    send_req(64'h60, 1);
    step();
    total++;
    if (busy !== 1'b1 || mem_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: busy=%b en=%b want 1 1", busy, mem_en);
    end
    rstn = 1'b0;
    #1;
    exp_q.delete();
    outstanding = 0;
    total++;
    if (req_rdy !== 1'b0 || rsp_vld !== 1'b0 || rsp_pd !== '0 || mem_en !== 1'b0 ||
        mem_addr !== '0 || cdt !== CW'(CDT) || ovf !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b vld=%b en=%b addr=%0d cdt=%0d ovf=%b busy=%b want 0 0 0 0 %0d 0 0",
               req_rdy, rsp_vld, mem_en, mem_addr, cdt, ovf, busy, CDT);
    end
    step();
    rstn = 1'b1;
    step();
    send_req({$urandom(), $urandom()}, 5);
    collect(10, 1'b1, 1'b1);
    drain_and_check();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      send_req({$urandom(), $urandom()}, $urandom_range(0, 9));
      collect(100, 1'b1, 1'b1);
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL random_leftover: iter=%0d left=%0d want 0", i, exp_q.size());
      end
      drain_and_check();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {8{$urandom()}};
    test_reset();
    test_single();
    test_three();
    test_credit_stall();
    test_backpressure();
    test_wrap();
    test_pop_coincident();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_dmaif_rd_responder.md
# nv_nvdla_sdp_dmaif_rd_responder

Memory-side responder for the SDP DMA read client interface. It accepts read requests (address plus atom count) on `dma_rd_req_*`, fetches 32-byte atoms from a synchronous backing RAM port, and packs them two per beat onto `dma_rd_rsp_*`. It enforces the client's latency-FIFO credit protocol through `dma_rd_cdt_lat_fifo_pop`. Used as the response end for RDMA units in block-level benches and as the core of the on-chip scratch read path.

## Interface
- `AW`, 64: request address width (bytes).
- `SW`, 15: request size width; the field holds the atom count minus 1.
- `ADW`, 256: atom data width (32 B).
- `MAW`, 10: backing RAM atom-index width.
- `CDT_DEPTH`, 16: client latency-FIFO depth, in beats.

Ports:
- `nvdla_core_clk`  in  1  clock.
- `nvdla_core_rstn`  in  1  reset, asynchronous, active-low.
- `dma_rd_req_vld`  in  1  request valid.
- `dma_rd_req_rdy`  out  1  request ready.
- `dma_rd_req_pd`  in  AW+SW  request payload: {size[SW-1:0], addr[AW-1:0]}.
- `dma_rd_rsp_vld`  out  1  response valid.
- `dma_rd_rsp_rdy`  in  1  response ready.
- `dma_rd_rsp_pd`  out  2*ADW+2  response payload: {mask[1:0], data_hi[ADW-1:0], data_lo[ADW-1:0]}.
- `dma_rd_cdt_lat_fifo_pop`  in  1  client returned one beat credit.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_rd_addr`  out  MAW  RAM atom index.
- `mem_rd_data`  in  ADW  RAM data, valid the cycle after `mem_rd_en`.
- `cdt_cnt`  out  clog2(CDT_DEPTH+1)  available credits.
- `cdt_ovf`  out  1  sticky credit-overflow error.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, CAP, SEND.
- **IDLE:** `dma_rd_req_rdy`=1. On vld&rdy:
  - ptr <= addr[MAW+4:5].
  - cnt <= size+1 (SW+1 bits).
  - Clear the beat register; go to RD_LO.
  - addr[4:0] is ignored.
- **RD_LO:** stall while `cdt_cnt`==0, with `mem_rd_en`=0. Otherwise:
  - Issue a read at ptr; ptr++, cnt--.
  - `cdt_cnt`-- (the beat is committed).
  - Next state: RD_HI if the new cnt != 0, else CAP with mask=2'b01.
- **RD_HI:**
  - Issue a read at ptr; ptr++, cnt--.
  - Capture `mem_rd_data` into data_lo.
  - Next state: CAP with mask=2'b11.
- **CAP:** capture `mem_rd_data` into data_hi if mask==11, else into data_lo. Next state: SEND.
- **SEND:** `dma_rd_rsp_vld`=1 and the payload is held stable. On rdy:
  - cnt==0: go to IDLE.
  - Otherwise: clear data and go to RD_LO.
- Unused half (mask 01): data_hi=0.
- ptr wraps modulo 2^MAW.
- **Credits:**
  - `cdt_cnt` resets to CDT_DEPTH.
  - Pop and RD_LO decrement in the same cycle: unchanged.
  - Pop while `cdt_cnt`==CDT_DEPTH and no decrement: count unchanged, `cdt_ovf`<=1 until reset.
- A new request is never accepted before the previous one's last beat is accepted.

## Timing
- **Reset values:**
  - `dma_rd_req_rdy`=0 during reset, 1 the first cycle after release (IDLE).
  - `dma_rd_rsp_vld`=0, `dma_rd_rsp_pd`=0.
  - `mem_rd_en`=0, `mem_rd_addr`=0.
  - `cdt_cnt`=CDT_DEPTH, `cdt_ovf`=0, `busy`=0.
- **Latency**, request accepted at cycle T, credits available, rdy=1:
  - First read at T+1.
  - 2-atom beat: `dma_rd_rsp_vld` at T+4.
  - 1-atom beat: `dma_rd_rsp_vld` at T+3.
  - Steady state: one full beat per 4 cycles.
- **Backpressure:** while in SEND with rdy=0:
  - No RAM reads and no credit change.
  - `dma_rd_rsp_pd` stays constant.
- All outputs are registered except `dma_rd_req_rdy`, `dma_rd_rsp_vld`, `mem_rd_en` and `busy`, which are decoded from the state register. `mem_rd_en` also depends on `cdt_cnt`; nothing depends combinationally on inputs.
- **Mid-operation reset:** an asserted `nvdla_core_rstn` immediately forces all state to reset values. Any in-flight beat is dropped and credits are restored to CDT_DEPTH.

## Test plan
- **Single atom.** mem[2]=A; request addr=0x40, size=0 at T.
  - `mem_rd_en`/addr=2 at T+1.
  - Response at T+3: mask=01, lo=A, hi=0.
  - `cdt_cnt` 16→15.
- **Three atoms.** Request addr=0x0, size=2.
  - Beat 1: mask=11, {mem1,mem0}.
  - Beat 2: mask=01, {0,mem2}.
  - `cdt_cnt`=14; `busy` drops after beat 2 is accepted.
- **Credit stall.** Request size=39 with no pops.
  - Exactly 16 beats are issued, then FSM holds in RD_LO with `mem_rd_en`=0.
  - One pop → beat 17 issues its first read on the next cycle.
- **Backpressure.** rdy=0 for 5 cycles in SEND: pd stable, `mem_rd_en`=0 throughout, `cdt_cnt` constant.
- **Wrap and credit edges.**
  - Request addr=0x7FE0 (index 1023), size=1: reads at 1023 then 0.
  - Pop coincident with RD_LO: `cdt_cnt` unchanged.
  - Pop at `cdt_cnt`=16: stays 16, `cdt_ovf`=1 and sticky.
- **Reset mid-beat.** Assert reset during RD_HI: all outputs at reset values; after release, a fresh request completes normally.
